sigmoid_sequencer: RTL and testbench



---
 rtl/sigmoid_sequencer_pkg.sv | 14 +
 rtl/sigmoid_sequencer_if.sv | 35 +++
 rtl/sigmoid_pipe_stage.sv | 23 ++
 rtl/sigmoid_sequencer.sv | 102 ++++++++++
 tb/tb_sigmoid_sequencer.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/sigmoid_sequencer_pkg.sv
// Shared types and default sizes for the sigmoid activation stage and its neighbours.
package sigmoid_sequencer_pkg;

  localparam int unsigned DefWidth     = 8;
  localparam int unsigned DefDepthBits = 3;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/sigmoid_sequencer_if.sv
// Control handshake plus RES/SIG read and A write ports of the sigmoid sequencer.
interface sigmoid_sequencer_if
  import sigmoid_sequencer_pkg::*;
#(
  parameter int unsigned Width     = DefWidth,
  parameter int unsigned DepthBits = DefDepthBits
);

  logic                 Start;
  logic [DepthBits:0]   len;
  logic                 Busy;
  logic                 Done;
  logic                 RES_read_en;
  logic [DepthBits-1:0] RES_read_address;
  logic [Width-1:0]     RES_read_data_out;
  logic                 SIG_read_en;
  logic [Width-1:0]     SIG_read_address;
  logic [Width-1:0]     SIG_read_data_out;
  logic                 A_write_en;
  logic [DepthBits-1:0] A_write_address;
  logic [Width-1:0]     A_write_data_in;

  modport slave (
    input  Start, len, RES_read_data_out, SIG_read_data_out,
    output Busy, Done, RES_read_en, RES_read_address, SIG_read_en, SIG_read_address,
           A_write_en, A_write_address, A_write_data_in
  );

  modport master (
    output Start, len, RES_read_data_out, SIG_read_data_out,
    input  Busy, Done, RES_read_en, RES_read_address, SIG_read_en, SIG_read_address,
           A_write_en, A_write_address, A_write_data_in
  );

endinterface

// File: rtl/sigmoid_pipe_stage.sv
// One pipeline slice: registers a valid bit and the element index alongside it.
module sigmoid_pipe_stage #(
  parameter int unsigned IndexW = 3
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              valid,
  input  logic [IndexW-1:0] index,
  output logic              valid_dly,
  output logic [IndexW-1:0] index_dly
);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      valid_dly <= 1'b0;
      index_dly <= '0;
    end else begin
      valid_dly <= valid;
      index_dly <= index;
    end
  end

endmodule

// File: rtl/sigmoid_sequencer.sv
// Streams RES elements through the SIG lookup RAM into A, one element per clock.
module sigmoid_sequencer
  import sigmoid_sequencer_pkg::*;
#(
  parameter int unsigned width          = DefWidth,
  parameter int unsigned RES_depth_bits = DefDepthBits,
  parameter int unsigned A_depth_bits   = DefDepthBits,
  parameter int unsigned SIG_depth_bits = DefWidth
) (
  input logic                clk,
  input logic                aresetn,
  sigmoid_sequencer_if.slave bus
);

  // Counter is one bit wider than the address so a full-depth run cannot wrap early.
  localparam int unsigned CntW = A_depth_bits + 1;

  state_e                    state_q, state_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic [CntW-1:0]           len_q, len_d;
  logic                      res_en;
  logic [RES_depth_bits-1:0] res_addr;
  logic                      s1_valid, s2_valid;
  logic [A_depth_bits-1:0]   s1_index, s2_index;
  logic [SIG_depth_bits-1:0] sig_addr;
  logic [width-1:0]          a_data;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    unique case (state_q)
      StIdle: begin
        if (bus.Start) begin
          len_d   = bus.len;
          cnt_d   = '0;
          state_d = (bus.len == '0) ? StDone : StIssue;
        end
      end
      StIssue: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == len_q - CntW'(1)) state_d = StDrain;
      end
      // The last write is in flight once stage 1 is empty, so Done lands right after it.
      StDrain: if (!s1_valid) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    res_en   = (state_q == StIssue);
    res_addr = res_en ? cnt_q[RES_depth_bits-1:0] : '0;
    sig_addr = s1_valid ? bus.RES_read_data_out : '0;
    a_data   = s2_valid ? bus.SIG_read_data_out : '0;

    bus.Busy             = (state_q != StIdle);
    bus.Done             = (state_q == StDone);
    bus.RES_read_en      = res_en;
    bus.RES_read_address = res_addr;
    bus.SIG_read_en      = s1_valid;
    bus.SIG_read_address = sig_addr;
    bus.A_write_en       = s2_valid;
    bus.A_write_address  = s2_index;
    bus.A_write_data_in  = a_data;
  end

  sigmoid_pipe_stage #(
    .IndexW(A_depth_bits)
  ) u_stage_sig (
    .clk      (clk),
    .aresetn  (aresetn),
    .valid    (res_en),
    .index    (res_addr),
    .valid_dly(s1_valid),
    .index_dly(s1_index)
  );

  sigmoid_pipe_stage #(
    .IndexW(A_depth_bits)
  ) u_stage_a (
    .clk      (clk),
    .aresetn  (aresetn),
    .valid    (s1_valid),
    .index    (s1_index),
    .valid_dly(s2_valid),
    .index_dly(s2_index)
  );

endmodule

// File: tb/tb_sigmoid_sequencer.sv
// Self-checking bench: RAM models, a cycle-offset behavioural model and randomized runs.
module tb_sigmoid_sequencer;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  always #5 clk = ~clk;

  sigmoid_sequencer_if #(.Width(8), .DepthBits(3)) bus ();

  sigmoid_sequencer #(
    .width(8), .RES_depth_bits(3), .A_depth_bits(3), .SIG_depth_bits(8)
  ) dut (
    .clk    (clk),
    .aresetn(aresetn),
    .bus    (bus)
  );

  logic [7:0] res_mem[8];
  logic [7:0] sig_mem[256];
  logic [7:0] a_mem[8];
  logic [7:0] exp_a[8];
  int errors = 0;
  int checks = 0;
  int cyc = 0;     // cyc names the cycle that follows edge cyc-1
  int wa_cnt = 0;
  int done_cnt = 0;

  // Synchronous-read RAMs with one cycle of latency, plus the A write port.
  always @(posedge clk) begin
    if (bus.RES_read_en) bus.RES_read_data_out <= res_mem[bus.RES_read_address];
    if (bus.SIG_read_en) bus.SIG_read_data_out <= sig_mem[bus.SIG_read_address];
    if (bus.A_write_en) a_mem[bus.A_write_address] <= bus.A_write_data_in;
    if (bus.A_write_en) wa_cnt <= wa_cnt + 1;
    if (bus.Done) done_cnt <= done_cnt + 1;
    cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Model: m_d is the offset of the current cycle from the accepting edge (-1 = never started).
  int m_d = -1;
  int m_len = 0;

  function automatic int done_off(input int l);
    return (l == 0) ? 1 : l + 3;
  endfunction

  function automatic bit m_busy();
    return (m_d >= 1) && (m_d <= done_off(m_len));
  endfunction

  always @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      m_d <= -1;
    end else begin
      if (m_d >= 3 && m_d <= m_len + 2) exp_a[m_d-3] <= sig_mem[res_mem[m_d-3]];
      if (!m_busy() && bus.Start) begin
        m_d   <= 1;
        m_len <= int'(bus.len);
      end else if (m_d >= 0) begin
        m_d <= m_d + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!aresetn) begin
      check("reset_outs", {bus.Busy, bus.Done, bus.RES_read_en, bus.SIG_read_en,
                           bus.A_write_en}, 0);
    end else begin
      automatic int d = m_d;
      automatic bit e_res = (d >= 1) && (d <= m_len);
      automatic bit e_sig = (d >= 2) && (d <= m_len + 1);
      automatic bit e_a   = (d >= 3) && (d <= m_len + 2);
      check("busy", bus.Busy, m_busy());
      check("done", bus.Done, (d >= 1) && (d == done_off(m_len)));
      check("res_en", bus.RES_read_en, e_res);
      check("sig_en", bus.SIG_read_en, e_sig);
      check("a_en", bus.A_write_en, e_a);
      if (e_res) check("res_addr", bus.RES_read_address, d - 1);
      if (e_sig) check("sig_addr", bus.SIG_read_address, res_mem[d-2]);
      if (e_a) begin
        check("a_addr", bus.A_write_address, d - 3);
        check("a_data", bus.A_write_data_in, sig_mem[res_mem[d-3]]);
      end
    end
  end

  task automatic start_run(input int l, output int t_acc);
    @(posedge clk);
    #1 bus.Start = 1'b1;
    bus.len = 4'(l);
    @(posedge clk);
    #1 t_acc = cyc - 1;
    bus.Start = 1'b0;
  endtask

  // Bounded wait for Done; optionally spams Start with random len while the run is busy.
  task automatic wait_done(input bit spam, output int dc);
    dc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.Done) begin
        dc = cyc;
        break;
      end
      bus.Start = spam && ($urandom_range(0, 2) == 0);
      bus.len   = 4'($urandom_range(0, 8));
    end
    bus.Start = 1'b0;
    checks++;
    if (dc < 0) begin
      errors++;
      $display("FAIL done_timeout: got no Done required Done within 40 cycles");
    end
  endtask

  task automatic check_a_mem(input string name);
    for (int i = 0; i < 8; i++) check(name, a_mem[i], exp_a[i]);
  endtask

  initial begin
    int t, dc, wa0, dn0, l;
    bus.Start = 1'b0;
    bus.len   = '0;
    for (int i = 0; i < 8; i++) begin
      a_mem[i] = 8'h00;
      exp_a[i] = 8'h00;
    end
    for (int x = 0; x < 256; x++) sig_mem[x] = 8'(x) ^ 8'hA5;
    res_mem = '{8'd3, 8'd7, 8'd0, 8'd255, 8'd128, 8'd1, 8'd2, 8'd4};

    repeat (3) @(negedge clk);
    aresetn = 1'b1;
    repeat (10) @(posedge clk);
    #1 check("idle_no_writes", wa_cnt, 0);

    // Nominal full-depth run.
    start_run(8, t);
    wait_done(1'b0, dc);
    check("nom_done_cyc", dc - t, 11);
    @(posedge clk);
    #1 check("nom_a0", a_mem[0], 8'hA6);
    check("nom_a3", a_mem[3], 8'h5A);
    check("nom_a4", a_mem[4], 8'h25);
    check("nom_a7", a_mem[7], 8'hA1);
    check_a_mem("nom_a_mem");

    // Empty vector.
    wa0 = wa_cnt;
    start_run(0, t);
    wait_done(1'b0, dc);
    check("len0_done_cyc", dc - t, 1);
    check("len0_writes", wa_cnt - wa0, 0);

    // Short vector leaves upper A entries alone.
    res_mem = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
    start_run(3, t);
    wait_done(1'b0, dc);
    check("len3_done_cyc", dc - t, 6);
    @(posedge clk);
    #1 check("len3_a1", a_mem[1], 8'hB1);
    check("len3_a5", a_mem[5], 8'hA4);
    check_a_mem("len3_a_mem");

    // Start re-pulsed while busy and in the Done cycle.
    wa0 = wa_cnt;
    dn0 = done_cnt;
    start_run(4, t);
    @(posedge clk);
    #1 bus.Start = 1'b1;
    bus.len = 4'd7;
    @(posedge clk);
    #1 bus.Start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.Done) begin
        check("repulse_done_cyc", cyc - t, 7);
        bus.Start = 1'b1;
        bus.len   = 4'd5;
        break;
      end
    end
    @(posedge clk);
    #1 bus.Start = 1'b0;
    repeat (12) @(negedge clk);
    check("repulse_writes", wa_cnt - wa0, 4);
    check("repulse_dones", done_cnt - dn0, 1);

    // Asynchronous reset in the middle of a run.
    start_run(8, t);
    repeat (3) @(posedge clk);
    #1 aresetn = 1'b0;
    #1 check("rst_a_en", bus.A_write_en, 0);
    check("rst_busy", bus.Busy, 0);
    check("rst_sig_en", bus.SIG_read_en, 0);
    check("rst_res_en", bus.RES_read_en, 0);
    @(negedge clk);
    #1 aresetn = 1'b1;
    wa0 = wa_cnt;
    dn0 = done_cnt;
    repeat (12) @(negedge clk);
    check("rst_no_writes", wa_cnt - wa0, 0);
    check("rst_no_done", done_cnt - dn0, 0);
    check_a_mem("rst_a_mem");
    start_run(2, t);
    wait_done(1'b0, dc);
    check("post_rst_done_cyc", dc - t, 5);

    // Randomized runs with random contents, gaps and Start spam.
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < 8; i++) res_mem[i] = 8'($urandom);
      for (int x = 0; x < 256; x++) sig_mem[x] = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      l = $urandom_range(0, 8);
      start_run(l, t);
      wait_done(1'b1, dc);
      check("rand_done_cyc", dc - t, done_off(l));
      @(posedge clk);
      #1 check_a_mem("rand_a_mem");
    end

    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
